// File: rtl/aps_pkg.sv
// Shared definitions for the register-bank controller: opcodes, FSM states,
// register-bank input selects and the write-back select helper.
package aps_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LDA  = 4'h2,
    OP_LDB  = 4'h3,
    OP_MOV  = 4'h4,
    OP_IL5  = 4'h5,
    OP_IL6  = 4'h6,
    OP_HALT = 4'h7,
    OP_ALU0 = 4'h8,
    OP_ALU1 = 4'h9,
    OP_ALU2 = 4'hA,
    OP_ALU3 = 4'hB,
    OP_ALU4 = 4'hC,
    OP_ALU5 = 4'hD,
    OP_ALU6 = 4'hE,
    OP_ALU7 = 4'hF
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DECODE,
    ST_CPA_SU,
    ST_CPA_WR,
    ST_CPB_SU,
    ST_CPB_WR,
    ST_ALU_WAIT,
    ST_WB_SU,
    ST_WB_WR,
    ST_HALT,
    ST_ERR
  } state_e;

  localparam logic [2:0] SEL_INA   = 3'b000;
  localparam logic [2:0] SEL_INB   = 3'b001;
  localparam logic [2:0] SEL_CONST = 3'b010;
  localparam logic [2:0] SEL_ALU   = 3'b011;
  localparam logic [2:0] SEL_RB    = 3'b100;

  // ALU operands are always staged in R1 (A) and R2 (B).
  localparam logic [3:0] REG_OPA = 4'd1;
  localparam logic [3:0] REG_OPB = 4'd2;

  function automatic logic [2:0] wb_sel(input logic [3:0] op);
    logic [2:0] sel;
    sel = SEL_ALU;
    case (op)
      OP_LDI:  sel = SEL_CONST;
      OP_LDA:  sel = SEL_INA;
      OP_LDB:  sel = SEL_INB;
      OP_MOV:  sel = SEL_RB;
      default: sel = SEL_ALU;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/lat_cnt.sv
// Down-counter that times the ALU wait: load, decrement, and a zero flag.
module lat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         res,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (res) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/rb_ctrl.sv
// Register-bank controller: accepts one instruction at a time and sequences
// two-cycle (setup, write) register-bank writes, including ALU operand staging.
module rb_ctrl
  import aps_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        res,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [2:0]  InMuxAdd,
  output logic [7:0]  CUconst,
  output logic [3:0]  OutMuxAdd,
  output logic [3:0]  regAdd,
  output logic        writeEn,
  output logic [2:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        halted,
  output logic        illegal
);

  state_e      state_reg;
  logic [3:0]  op_reg;
  logic [3:0]  dst_reg;
  logic [7:0]  imm_reg;
  logic [2:0]  in_mux_reg;
  logic [7:0]  cu_reg;
  logic [3:0]  out_mux_reg;
  logic [3:0]  reg_add_reg;
  logic        we_reg;
  logic [2:0]  alu_op_reg;
  logic        done_reg;

  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic        need_a;
  logic        need_b;
  logic        b_first;
  logic        cnt_zero;

  assign src_a   = imm_reg[7:4];
  assign src_b   = imm_reg[3:0];
  assign need_a  = (src_a != REG_OPA);
  assign need_b  = (src_b != REG_OPB);
  // Copying A first would clobber R1 before B reads it.
  assign b_first = (src_b == REG_OPA) && (src_a != REG_OPA);

  lat_cnt #(.W(4)) u_lat_cnt (
    .clk      (clk),
    .res      (res),
    .load     (state_reg != ST_ALU_WAIT),
    .load_val (4'(ALU_LAT - 1)),
    .dec      (state_reg == ST_ALU_WAIT),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg   <= ST_IDLE;
      op_reg      <= '0;
      dst_reg     <= '0;
      imm_reg     <= '0;
      in_mux_reg  <= '0;
      cu_reg      <= '0;
      out_mux_reg <= '0;
      reg_add_reg <= '0;
      we_reg      <= 1'b0;
      alu_op_reg  <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (instr_valid) begin
            op_reg    <= instr[15:12];
            dst_reg   <= instr[11:8];
            imm_reg   <= instr[7:0];
            if (instr[15]) alu_op_reg <= instr[14:12];
            done_reg  <= (instr[15:12] == OP_NOP);
            state_reg <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (op_reg[3]) begin
            if (src_a == REG_OPB && src_b == REG_OPA) begin
              state_reg <= ST_ERR;
            end else if (b_first || !need_a) begin
              in_mux_reg  <= SEL_RB;
              out_mux_reg <= src_b;
              reg_add_reg <= REG_OPB;
              state_reg   <= need_b ? ST_CPB_SU : ST_ALU_WAIT;
            end else begin
              in_mux_reg  <= SEL_RB;
              out_mux_reg <= src_a;
              reg_add_reg <= REG_OPA;
              state_reg   <= ST_CPA_SU;
            end
          end else begin
            case (op_reg)
              OP_NOP: state_reg <= ST_IDLE;
              OP_LDI, OP_LDA, OP_LDB, OP_MOV: begin
                in_mux_reg  <= wb_sel(op_reg);
                reg_add_reg <= dst_reg;
                if (op_reg == OP_LDI) cu_reg <= imm_reg;
                if (op_reg == OP_MOV) out_mux_reg <= src_a;
                state_reg   <= ST_WB_SU;
              end
              OP_HALT: state_reg <= ST_HALT;
              default: state_reg <= ST_ERR;
            endcase
          end
        end
        ST_CPA_SU: begin
          we_reg    <= 1'b1;
          state_reg <= ST_CPA_WR;
        end
        ST_CPA_WR: begin
          we_reg <= 1'b0;
          if (!b_first && need_b) begin
            out_mux_reg <= src_b;
            reg_add_reg <= REG_OPB;
            state_reg   <= ST_CPB_SU;
          end else begin
            state_reg <= ST_ALU_WAIT;
          end
        end
        ST_CPB_SU: begin
          we_reg    <= 1'b1;
          state_reg <= ST_CPB_WR;
        end
        ST_CPB_WR: begin
          we_reg <= 1'b0;
          if (b_first) begin
            out_mux_reg <= src_a;
            reg_add_reg <= REG_OPA;
            state_reg   <= ST_CPA_SU;
          end else begin
            state_reg <= ST_ALU_WAIT;
          end
        end
        ST_ALU_WAIT: begin
          if (cnt_zero) begin
            in_mux_reg  <= SEL_ALU;
            reg_add_reg <= dst_reg;
            state_reg   <= ST_WB_SU;
          end
        end
        ST_WB_SU: begin
          we_reg    <= 1'b1;
          done_reg  <= 1'b1;
          state_reg <= ST_WB_WR;
        end
        ST_WB_WR: begin
          we_reg    <= 1'b0;
          state_reg <= ST_IDLE;
        end
        ST_HALT: state_reg <= ST_HALT;
        ST_ERR:  state_reg <= ST_ERR;
        default: state_reg <= ST_ERR;
      endcase
    end
  end

  assign instr_ready = (state_reg == ST_IDLE);
  assign busy        = !((state_reg == ST_IDLE) || (state_reg == ST_HALT) || (state_reg == ST_ERR));
  assign halted      = (state_reg == ST_HALT);
  assign illegal     = (state_reg == ST_ERR);
  assign InMuxAdd    = in_mux_reg;
  assign CUconst     = cu_reg;
  assign OutMuxAdd   = out_mux_reg;
  assign regAdd      = reg_add_reg;
  assign writeEn     = we_reg;
  assign alu_op      = alu_op_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_rb_ctrl.sv
// Bench for rb_ctrl: directed scenarios plus random instructions checked
// against a write-list reference model.
module tb_rb_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  InMuxAdd;
  logic [7:0]  CUconst;
  logic [3:0]  OutMuxAdd;
  logic [3:0]  regAdd;
  logic        writeEn;
  logic [2:0]  alu_op;
  logic        busy;
  logic        done;
  logic        halted;
  logic        illegal;

  rb_ctrl #(.ALU_LAT(LAT)) dut (
    .clk         (clk),
    .res         (res),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .InMuxAdd    (InMuxAdd),
    .CUconst     (CUconst),
    .OutMuxAdd   (OutMuxAdd),
    .regAdd      (regAdd),
    .writeEn     (writeEn),
    .alu_op      (alu_op),
    .busy        (busy),
    .done        (done),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] ra;
    logic [2:0] mux;
    logic [3:0] om;
    logic [7:0] cu;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read-back address matters only for register copies, the constant only for LDI.
  function automatic wr_t mk(input logic [3:0] ra, input logic [2:0] mux,
                             input logic [3:0] om, input logic [7:0] cu);
    wr_t w;
    w.ra  = ra;
    w.mux = mux;
    w.om  = (mux == 3'b100) ? om : 4'h0;
    w.cu  = (mux == 3'b010) ? cu : 8'h00;
    return w;
  endfunction

  task automatic model(input logic [15:0] ins, output int lat);
    logic [3:0] op, dst, a, b;
    int n;
    op  = ins[15:12];
    dst = ins[11:8];
    a   = ins[7:4];
    b   = ins[3:0];
    n   = 0;
    exp_q.delete();
    lat = 3;
    case (op)
      4'h0: lat = 1;
      4'h1: exp_q.push_back(mk(dst, 3'b010, 4'h0, ins[7:0]));
      4'h2: exp_q.push_back(mk(dst, 3'b000, 4'h0, 8'h00));
      4'h3: exp_q.push_back(mk(dst, 3'b001, 4'h0, 8'h00));
      4'h4: exp_q.push_back(mk(dst, 3'b100, a, 8'h00));
      default: begin
        if (b == 4'd1 && a != 4'd1) begin
          exp_q.push_back(mk(4'd2, 3'b100, b, 8'h00));
          exp_q.push_back(mk(4'd1, 3'b100, a, 8'h00));
          n = 2;
        end else begin
          if (a != 4'd1) begin exp_q.push_back(mk(4'd1, 3'b100, a, 8'h00)); n++; end
          if (b != 4'd2) begin exp_q.push_back(mk(4'd2, 3'b100, b, 8'h00)); n++; end
        end
        exp_q.push_back(mk(dst, 3'b011, 4'h0, 8'h00));
        lat = 3 + 2 * n + LAT;
      end
    endcase
  endtask

  // Offer one instruction, optionally keep junk on instr_valid while busy,
  // and compare the observed write list and retire latency with the model.
  task automatic exec(input logic [15:0] ins, input bit hold, input string tag);
    int lat;
    int k;
    bit seen;
    logic prev_we;
    wr_t prev, cur;
    model(ins, lat);
    obs_q.delete();
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    check({tag, ".ready"}, 32'(instr_ready), 32'(1'b1));
    @(negedge clk);
    instr_valid = hold;
    instr = 16'($urandom);
    prev_we = 1'b1;
    prev = '0;
    seen = 1'b0;
    for (k = 1; k <= 60; k++) begin
      cur = mk(regAdd, InMuxAdd, OutMuxAdd, CUconst);
      if (k == 1) check({tag, ".busy"}, 32'(busy), 32'(1'b1));
      if (writeEn) begin
        obs_q.push_back(cur);
        check($sformatf("%s.setup%0d", tag, obs_q.size()), 32'({prev_we, prev}), 32'({1'b0, cur}));
        if (ins[15]) check({tag, ".alu_op"}, 32'(alu_op), 32'(ins[14:12]));
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      prev_we = writeEn;
      prev = cur;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check({tag, ".lat"}, seen ? 32'(k) : 32'd999, 32'(lat));
    check({tag, ".nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s.wr%0d", tag, i), (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hFFFFFFFF,
            32'(exp_q[i]));
    end
    $display("[TB] %s instr=%h writes=%0d latency=%0d", tag, ins, obs_q.size(), k);
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    res = 1'b0;
  endtask

  initial begin
    int nwe;
    logic [3:0] op, a, b;
    logic [15:0] ins;

    // Reset state
    repeat (3) @(negedge clk);
    res = 1'b0;
    check("rst.ready", 32'(instr_ready), 32'(1'b1));
    check("rst.busy", 32'(busy), 32'(1'b0));
    check("rst.done", 32'(done), 32'(1'b0));
    check("rst.flags", 32'({halted, illegal, writeEn}), 32'(3'b000));
    check("rst.sel", 32'({InMuxAdd, OutMuxAdd, regAdd, CUconst, alu_op}), 32'd0);
    $display("[TB] reset state checked");

    // Directed instructions
    exec(16'h15A7, 1'b0, "ldi");
    exec(16'h9346, 1'b1, "alu_ab");
    exec(16'h8271, 1'b0, "alu_bfirst");
    exec(16'hC012, 1'b1, "alu_nocopy");
    exec(16'h4057, 1'b0, "mov_r0");
    exec(16'h0000, 1'b1, "nop");

    // Random instructions
    for (int t = 0; t < 40; t++) begin
      int r;
      r  = int'($urandom_range(12));
      op = (r < 5) ? 4'(r) : 4'(r + 3);
      a  = 4'($urandom_range(15));
      b  = 4'($urandom_range(15));
      if ($urandom_range(2) == 0) a = 4'($urandom_range(2, 1));
      if ($urandom_range(2) == 0) b = 4'($urandom_range(2, 1));
      if (op[3] && a == 4'd2 && b == 4'd1) b = 4'd3;
      ins = {op, 4'($urandom_range(15)), a, b};
      exec(ins, 1'($urandom_range(1)), $sformatf("rnd%0d", t));
    end

    // Illegal operand combination: no writes, controller locks up
    @(negedge clk);
    instr = 16'hA021;
    instr_valid = 1'b1;
    @(negedge clk);
    instr = 16'h1155;
    nwe = 0;
    for (int i = 0; i < 10; i++) begin
      if (writeEn) nwe++;
      @(negedge clk);
    end
    check("ill21.illegal", 32'(illegal), 32'(1'b1));
    check("ill21.ready", 32'(instr_ready), 32'(1'b0));
    check("ill21.busy", 32'(busy), 32'(1'b0));
    check("ill21.nwe", 32'(nwe), 32'd0);
    $display("[TB] ill21 illegal=%0d writes=%0d", illegal, nwe);
    do_reset();
    check("ill21.clr", 32'({illegal, instr_ready}), 32'(2'b01));

    // Illegal opcode 5
    @(negedge clk);
    instr = 16'h5123;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("op5.illegal", 32'({illegal, writeEn}), 32'(2'b10));
    $display("[TB] op5 illegal=%0d", illegal);
    do_reset();

    // HALT with instr_valid held high afterwards
    @(negedge clk);
    instr = 16'h7000;
    instr_valid = 1'b1;
    @(negedge clk);
    instr = 16'h1155;
    nwe = 0;
    for (int i = 0; i < 10; i++) begin
      if (writeEn) nwe++;
      @(negedge clk);
    end
    check("halt.halted", 32'(halted), 32'(1'b1));
    check("halt.ready", 32'(instr_ready), 32'(1'b0));
    check("halt.nwe", 32'(nwe), 32'd0);
    $display("[TB] halt halted=%0d writes=%0d", halted, nwe);
    do_reset();
    check("halt.clr", 32'({halted, instr_ready}), 32'(2'b01));

    // Reset while in CPB_SU of an ALU instruction
    @(negedge clk);
    instr = 16'h9346;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.cpb_su", 32'({writeEn, regAdd, InMuxAdd}), 32'({1'b0, 4'd2, 3'b100}));
    res = 1'b1;
    @(negedge clk);
    check("abort.after", 32'({writeEn, instr_ready, busy}), 32'(3'b010));
    res = 1'b0;
    $display("[TB] abort writeEn=%0d ready=%0d", writeEn, instr_ready);
    exec(16'h2A00, 1'b0, "post_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
